// File: rtl/rfc_pkg.sv
// Shared definitions for the register-file controller: opcode encodings
// and the controller FSM state enumeration.
package rfc_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_MOV = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rfc_alu.sv
// Combinational ALU for the register-file controller.
// LDI and MOV pass operand a through; ADD/SUB report carry/borrow on c_o,
// all other operations return c_o = 0.
module rfc_alu
    import rfc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o,
    output logic              c_o
);

    logic [DATA_W:0] ext;

    // One extra bit on add/sub: for SUB it becomes 1 exactly when a < b.
    always_comb begin
        y_o = '0;
        c_o = 1'b0;
        ext = '0;
        case (op_e'(op_i))
            OP_LDI, OP_MOV: y_o = a_i;
            OP_ADD: begin
                ext = {1'b0, a_i} + {1'b0, b_i};
                y_o = ext[DATA_W-1:0];
                c_o = ext[DATA_W];
            end
            OP_SUB: begin
                ext = {1'b0, a_i} - {1'b0, b_i};
                y_o = ext[DATA_W-1:0];
                c_o = ext[DATA_W];
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_controller.sv
// Register-file controller: accepts one command at a time, reads up to two
// source registers, runs the ALU and writes the destination register.
// Optional macro RFC_FLAGS_EN enables the carry/zero flag registers;
// without it flag_c and flag_z are tied to 0.
//
// Handshake: a command is taken on the rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE (including the done
// cycle), so the source may hold cmd_valid high for back-to-back commands.
module regfile_controller
    import rfc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs0,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rf_we_n,
    output logic              rf_oe_n,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [ADDR_W-1:0] rf_raddr0,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata0,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    output logic [1:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, raddr0_q, raddr1_q, waddr_q;
    logic [DATA_W-1:0] imm_q, wdata_q, result_q;
    logic              done_q;
    logic [DATA_W-1:0] alu_a, alu_y;
    logic              alu_c;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: NOP stays in IDLE, LDI skips the read, others read first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LDI)      state_d = ST_EXEC;
                    else if (cmd_op != OP_NOP) state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // LDI feeds the immediate through operand a; everything else uses rs0.
    assign alu_a = (op_q == OP_LDI) ? imm_q : rf_rdata0;

    rfc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (op_q),
        .a_i  (alu_a),
        .b_i  (rf_rdata1),
        .y_o  (alu_y),
        .c_o  (alu_c)
    );

    // Command latch, write-port registers, visible result and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            rd_q     <= '0;
            raddr0_q <= '0;
            raddr1_q <= '0;
            imm_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q     <= cmd_op;
                rd_q     <= cmd_rd;
                raddr0_q <= cmd_rs0;
                raddr1_q <= cmd_rs1;
                imm_q    <= cmd_imm;
                if (cmd_op == OP_NOP) done_q <= 1'b1;
            end
            if (state_q == ST_EXEC) begin
                waddr_q <= rd_q;
                wdata_q <= alu_y;
            end
            // result only moves together with done so it holds between dones
            if (state_q == ST_WRITE) begin
                result_q <= wdata_q;
                done_q   <= 1'b1;
            end
        end
    end

`ifdef RFC_FLAGS_EN
    logic carry_q, flag_c_q, flag_z_q;

    // Carry is captured with the ALU result and published at done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q  <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            if (state_q == ST_EXEC) carry_q <= alu_c;
            if (state_q == ST_WRITE) begin
                flag_c_q <= carry_q;
                flag_z_q <= (wdata_q == '0);
            end
        end
    end

    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;
`else
    logic unused_alu_c;
    assign unused_alu_c = alu_c;
    assign flag_c = 1'b0;
    assign flag_z = 1'b0;
`endif

    // Strobes decode straight from the state, so read and write are exclusive.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign rf_oe_n     = (state_q != ST_READ);
    assign rf_we_n     = (state_q != ST_WRITE);
    assign rf_raddr0   = raddr0_q;
    assign rf_raddr1   = raddr1_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_controller.sv
// Self-checking bench for regfile_controller: a table of directed commands,
// hand-written back-to-back and reset-abort sequences, then random commands
// checked against a behavioural model of the register file and flags.
module tb_regfile_controller;

    localparam int DW = 16;
    localparam int AW = 3;
`ifdef RFC_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_rs0 = '0, cmd_rs1 = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic          rf_we_n, rf_oe_n;
    logic [AW-1:0] rf_waddr, rf_raddr0, rf_raddr1;
    logic [DW-1:0] rf_wdata, rf_rdata0, rf_rdata1;
    logic          done, flag_c, flag_z;
    logic [DW-1:0] result;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    regfile_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs0     (cmd_rs0),
        .cmd_rs1     (cmd_rs1),
        .cmd_imm     (cmd_imm),
        .rf_we_n     (rf_we_n),
        .rf_oe_n     (rf_oe_n),
        .rf_waddr    (rf_waddr),
        .rf_raddr0   (rf_raddr0),
        .rf_raddr1   (rf_raddr1),
        .rf_wdata    (rf_wdata),
        .rf_rdata0   (rf_rdata0),
        .rf_rdata1   (rf_rdata1),
        .done        (done),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .dbg_state_o (dbg_state)
    );

    // Register file attached to the controller: synchronous read and write.
    logic [DW-1:0] rf_mem [8];
    always @(posedge clk) begin
        if (!rf_we_n) rf_mem[rf_waddr] <= rf_wdata;
        if (!rf_oe_n) begin
            rf_rdata0 <= rf_mem[rf_raddr0];
            rf_rdata1 <= rf_mem[rf_raddr1];
        end
    end

    // Bus monitor, sampled mid-cycle.
    int            we_cnt = 0, oe_cnt = 0, done_cnt = 0, overlap_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;
    always @(negedge clk) begin
        if (!rf_we_n) begin
            we_cnt++;
            last_waddr = rf_waddr;
            last_wdata = rf_wdata;
        end
        if (!rf_oe_n) oe_cnt++;
        if (done) done_cnt++;
        if (!rf_we_n && !rf_oe_n) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: architectural registers plus the visible result/flags.
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] ref_res = '0;
    logic          ref_c = 1'b0, ref_z = 1'b0;

    task automatic model(input logic [2:0] op, input logic [AW-1:0] rd, rs0, rs1,
                         input logic [DW-1:0] imm, output int lat);
        int a, b, y;
        bit c;
        a = int'(ref_mem[rs0]);
        b = int'(ref_mem[rs1]);
        y = 0;
        c = 1'b0;
        if (op == 3'd0) begin
            lat = 1;
            return;
        end
        case (op)
            3'd1: y = int'(imm);
            3'd2: y = a;
            3'd3: begin y = (a + b) % 65536; c = (a + b) > 65535; end
            3'd4: begin y = (a - b + 65536) % 65536; c = (a < b); end
            3'd5: y = a & b;
            3'd6: y = a | b;
            default: y = a ^ b;
        endcase
        ref_mem[rd] = y[DW-1:0];
        ref_res = y[DW-1:0];
        ref_z = (y == 0);
        ref_c = c;
        lat = (op == 3'd1) ? 3 : 4;
    endtask

    // Drive one command and count cycles from the accept edge to done.
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, rs0, rs1,
                           input logic [DW-1:0] imm, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rs0 = rs0; cmd_rs1 = rs1; cmd_imm = imm;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic exec_check(input logic [2:0] op, input logic [AW-1:0] rd, rs0, rs1,
                              input logic [DW-1:0] imm, input logic [DW-1:0] e_res,
                              input logic e_c, input logic e_z, input int e_lat);
        int we0, oe0, d0, lat;
        we0 = we_cnt; oe0 = oe_cnt; d0 = done_cnt;
        run_cmd(op, rd, rs0, rs1, imm, lat);
        check("latency", lat, e_lat);
        check("result", result, e_res);
        check("flag_c", flag_c, FLAGS_EN ? e_c : 1'b0);
        check("flag_z", flag_z, FLAGS_EN ? e_z : 1'b0);
        check("done_pulses", done_cnt - d0, 1);
        check("done_width", done, 0);
        check("we_cycles", we_cnt - we0, (op != 3'd0) ? 1 : 0);
        check("oe_cycles", oe_cnt - oe0, (op >= 3'd2) ? 1 : 0);
        if (op != 3'd0) begin
            check("waddr", last_waddr, rd);
            check("wdata", last_wdata, e_res);
        end
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rd, rs0, rs1;
        logic [DW-1:0] imm;
        logic [DW-1:0] res;
        logic          c, z;
        int            lat;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int lat, we0, d0;
        logic [2:0] op;
        logic [AW-1:0] rd, rs0, rs1;
        logic [DW-1:0] imm;

        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        // Expected values worked out by hand (flags shown for the flag build).
        tbl[0]  = '{3'd1, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 3};
        tbl[1]  = '{3'd1, 3'd2, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 3};
        tbl[2]  = '{3'd1, 3'd3, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 3};
        tbl[3]  = '{3'd3, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b1, 4};
        tbl[4]  = '{3'd1, 3'd2, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0, 3};
        tbl[5]  = '{3'd1, 3'd4, 3'd0, 3'd0, 16'h0007, 16'h0007, 1'b0, 1'b0, 3};
        tbl[6]  = '{3'd4, 3'd2, 3'd2, 3'd4, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 4};
        tbl[7]  = '{3'd2, 3'd5, 3'd2, 3'd2, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 4};
        tbl[8]  = '{3'd5, 3'd6, 3'd5, 3'd4, 16'h0000, 16'h0006, 1'b0, 1'b0, 4};
        tbl[9]  = '{3'd6, 3'd7, 3'd6, 3'd4, 16'h0000, 16'h0007, 1'b0, 1'b0, 4};
        tbl[10] = '{3'd7, 3'd0, 3'd7, 3'd4, 16'h0000, 16'h0000, 1'b0, 1'b1, 4};
        tbl[11] = '{3'd0, 3'd1, 3'd2, 3'd3, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1};
        tbl[12] = '{3'd4, 3'd1, 3'd4, 3'd6, 16'h0000, 16'h0001, 1'b0, 1'b0, 4};

        // reset state
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_we_n", rf_we_n, 1);
        check("rst_oe_n", rf_oe_n, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_raddr0", rf_raddr0, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_flags", {flag_c, flag_z}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 13; i++) begin
            model(tbl[i].op, tbl[i].rd, tbl[i].rs0, tbl[i].rs1, tbl[i].imm, lat);
            exec_check(tbl[i].op, tbl[i].rd, tbl[i].rs0, tbl[i].rs1, tbl[i].imm,
                       tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].lat);
        end
        for (int i = 0; i < 8; i++) check("regs_after_table", rf_mem[i], ref_mem[i]);

        // back-to-back: ADD r3=r1+r4 then LDI r6 with cmd_valid held high
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd3; cmd_rd = 3'd3; cmd_rs0 = 3'd1; cmd_rs1 = 3'd4; cmd_imm = '0;
        model(3'd3, 3'd3, 3'd1, 3'd4, 16'h0000, lat);
        @(posedge clk);
        #1;
        cmd_op = 3'd1; cmd_rd = 3'd6; cmd_imm = 16'hABCD;
        lat = 1;
        while (!done && lat < 12) begin @(posedge clk); #1; lat++; end
        check("b2b_first_latency", lat, 4);
        check("b2b_ready_in_done", cmd_ready, 1);
        check("b2b_first_result", result, 16'h0008);
        model(3'd1, 3'd6, 3'd1, 3'd4, 16'hABCD, lat);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin @(posedge clk); #1; lat++; end
        check("b2b_second_latency", lat, 3);
        check("b2b_second_result", result, 16'hABCD);
        check("b2b_flag_z", flag_z, 1'b0);
        @(posedge clk);
        #1;

        // reset pulsed during READ of XOR r5=r6^r7
        we0 = we_cnt; d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd7; cmd_rd = 3'd5; cmd_rs0 = 3'd6; cmd_rs1 = 3'd7;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("abort_in_read", rf_oe_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_oe_n", rf_oe_n, 1);
        check("abort_ready", cmd_ready, 1);
        check("abort_result", result, 0);
        check("abort_wdata", rf_wdata, 0);
        check("abort_raddr1", rf_raddr1, 0);
        ref_res = '0; ref_c = 1'b0; ref_z = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after", cmd_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_write", we_cnt - we0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_regs_kept", rf_mem[5], ref_mem[5]);

        // random commands against the model
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs0 = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            imm = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            model(op, rd, rs0, rs1, imm, lat);
            exec_check(op, rd, rs0, rs1, imm, ref_res, ref_c, ref_z, lat);
        end
        for (int i = 0; i < 8; i++) check("regs_after_random", rf_mem[i], ref_mem[i]);

        check("we_oe_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_controller.md
REGFILE_CONTROLLER -- requirements
Module: regfile_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and operand width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 3, cmd_rd/cmd_rs0/cmd_rs1 in ADDR_W, cmd_imm in DATA_W: command handshake.
REQ-006 SHALL have ports rf_we_n out 1, rf_oe_n out 1: register-file write and read enables, active-low.
REQ-007 SHALL have ports rf_waddr, rf_raddr0, rf_raddr1 out ADDR_W, and rf_wdata out DATA_W: register-file addresses and write data.
REQ-008 SHALL have ports rf_rdata0, rf_rdata1 in DATA_W: register-file read data.
REQ-009 SHALL have ports done out 1 (one-cycle pulse), result out DATA_W, flag_c out 1, flag_z out 1.

Function
REQ-010 SHALL decode cmd_op: 0 NOP, 1 LDI (rd=imm), 2 MOV (rd=rs0), 3 ADD, 4 SUB (rs0-rs1), 5 AND, 6 OR, 7 XOR.
REQ-011 SHALL implement FSM states IDLE, READ, EXEC, WRITE; cmd_ready=1 only in IDLE.
REQ-012 SHALL accept a command on the rising edge where cmd_valid & cmd_ready, latching all cmd_* fields.
REQ-013 SHALL transition IDLE->READ for MOV/ALU ops, IDLE->EXEC for LDI, and IDLE->IDLE with done pulse next cycle for NOP.
REQ-014 SHALL drive rf_oe_n=0 only in READ, with rf_raddr0/1 = latched rs0/rs1; READ->EXEC unconditionally.
REQ-015 SHALL in EXEC capture rf_rdata0/1, compute the result into a register, and drive rf_waddr=rd and rf_wdata=result from the end of EXEC; EXEC->WRITE.
REQ-016 SHALL drive rf_we_n=0 for exactly one cycle in WRITE, with rf_waddr/rf_wdata stable from one cycle before through the end of that cycle; WRITE->IDLE with done=1 for one cycle.
REQ-017 SHALL compute ADD/SUB modulo 2^DATA_W; carry = bit DATA_W of the unsigned sum, and for SUB carry = borrow (rs0<rs1).
REQ-018 SHALL yield latency accept-edge to done: ALU/MOV 4 cycles, LDI 3 cycles, NOP 1 cycle; throughput one command per latency+0 cycles (cmd_ready reasserts in the done cycle).
REQ-019 SHALL handle rd equal to rs0 or rs1 correctly, since read completes before write.
REQ-020 SHALL never assert rf_we_n=0 and rf_oe_n=0 in the same cycle.
REQ-021 SHALL hold result until the next done.

Reset
REQ-022 SHALL on rst_n=0, immediately and asynchronously, force state IDLE, rf_we_n=1, rf_oe_n=1, done=0, all addresses, rf_wdata, result, flag_c and flag_z to 0.
REQ-023 SHALL abort any in-flight command on reset, without a register-file write or done pulse; cmd_ready=1 at the first edge after release.

Configuration
REQ-024 SHALL support macro RFC_FLAGS_EN: when defined, flag_c/flag_z update at done (flag_z = result==0; flag_c per REQ-017 for ADD/SUB, 0 for other ops, unchanged for NOP); when undefined, both ports are tied 0 and the flag logic is absent.

Structure
REQ-025 SHALL take opcode encodings and the FSM state enumeration from a shared package rfc_pkg.
REQ-026 SHALL place the arithmetic in one sub-module rfc_alu (combinational: op, a, b -> y, c).

Verification
REQ-027 SHALL cover LDI r3,0x1234 -> we_n low 1 cycle, waddr=3, wdata=0x1234, done 3 cycles after accept.
REQ-028 SHALL cover ADD r1=r2+r3 with r2=0xFFFF, r3=0x0001 -> result 0x0000, flag_c=1, flag_z=1 (RFC_FLAGS_EN defined) or both 0 (undefined).
REQ-029 SHALL cover SUB r2=r2-r4 with r2=5, r4=7 -> result 0xFFFE written to r2, flag_c=1, flag_z=0.
REQ-030 SHALL cover back-to-back commands with cmd_valid held high -> second accepted in the done cycle of the first; we_n and oe_n never both 0.
REQ-031 SHALL cover rst_n pulsed low during READ of an XOR -> we_n stays 1, no done pulse, cmd_ready=1 after release.
REQ-032 SHALL cover NOP -> done 1 cycle after accept, no register-file access, result unchanged.
